// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//
// Shared definitions for the carry-lookahead adder:
//   GROUP_W     - width of one lookahead slice (4 bits)
//   MAX_WIDTH   - widest adder this lookahead tree supports (16 groups)
//   gpg_t       - {generate, propagate} pair. Used for single bits, 4-bit
//                 groups and 16-bit clusters alike, because the lookahead
//                 algebra is the same at every level.
//   num_groups  - number of 4-bit groups for a given adder width
//   lookahead4  - flat sum-of-products carries for four {g,p} pairs
//   carry_at    - one carry picked out of lookahead4
//   group_pg    - combined {GG, GP} of four {g,p} pairs
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W   = 4;
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic gg;   // generate: this span produces a carry on its own
        logic gp;   // propagate: this span passes an incoming carry through
    } gpg_t;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // Carries c[0..4] for four {g,p} pairs fed by cin. Every carry is a
    // two-level AND-OR of the pairs and cin; no term depends on another carry,
    // so the depth does not grow with position.
    function automatic logic [4:0] lookahead4(input gpg_t [3:0] x, input logic cin);
        logic [4:0] c;
        c[0] = cin;
        c[1] = x[0].gg
             | (x[0].gp & cin);
        c[2] = x[1].gg
             | (x[1].gp & x[0].gg)
             | (x[1].gp & x[0].gp & cin);
        c[3] = x[2].gg
             | (x[2].gp & x[1].gg)
             | (x[2].gp & x[1].gp & x[0].gg)
             | (x[2].gp & x[1].gp & x[0].gp & cin);
        c[4] = x[3].gg
             | (x[3].gp & x[2].gg)
             | (x[3].gp & x[2].gp & x[1].gg)
             | (x[3].gp & x[2].gp & x[1].gp & x[0].gg)
             | (x[3].gp & x[2].gp & x[1].gp & x[0].gp & cin);
        return c;
    endfunction

    function automatic logic carry_at(input gpg_t [3:0] x, input logic cin,
                                      input logic [2:0] j);
        logic [4:0] c;
        c = lookahead4(x, cin);
        return c[j];
    endfunction

    function automatic gpg_t group_pg(input gpg_t [3:0] x);
        gpg_t r;
        r.gg = x[3].gg
             | (x[3].gp & x[2].gg)
             | (x[3].gp & x[2].gp & x[1].gg)
             | (x[3].gp & x[2].gp & x[1].gp & x[0].gg);
        r.gp = x[3].gp & x[2].gp & x[1].gp & x[0].gp;
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
//
// 4-bit carry-lookahead slice. Internal carries come straight from the
// slice's own {g,p} bits and cin, with no ripple. The slice also exports its
// group generate/propagate so the next level up can look ahead across groups.
//
// Ports:
//   a, b  [3:0]  operand bits for this slice
//   cin          carry into bit 0 of the slice
//   sum   [3:0]  sum bits
//   gg           group generate (independent of cin)
//   gp           group propagate (independent of cin)
// -----------------------------------------------------------------------------
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       gg,
    output logic       gp
);

    gpg_t [3:0] bit_pg;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bit_pg[i].gg = a[i] & b[i];
            bit_pg[i].gp = a[i] ^ b[i];
        end
    end

    // gg/gp are computed apart from the sum so that they never appear to
    // depend on cin; the inter-group lookahead feeds cin back from them.
    assign {gg, gp} = group_pg(bit_pg);

    always_comb begin
        // NOTE: every bit of sum is written on every pass through this block,
        // so no latch can be inferred; any new output added here needs the same.
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = bit_pg[i].gp ^ carry_at(bit_pg, cin, 3'(i));
        end
    end

endmodule

// File: rtl/cla_adder.sv
// -----------------------------------------------------------------------------
// cla_adder
//
// Parameterised carry-lookahead adder: {Cout, Sum} = A + B + Cin.
// The lookahead is built in up to three levels:
//   level 1 - bit carries inside each 4-bit group (cla_group4)
//   level 2 - group carries inside each cluster of four groups
//   level 3 - cluster carries across up to four clusters (WIDTH > 16)
// Each level is a flat lookahead, so no ripple chain crosses a level.
// Sum/Cout are purely combinational. Sum_q/Cout_q are a registered copy
// for pipelined consumers.
//
// Ports:
//   clk     system clock, used only by Sum_q/Cout_q
//   rst_n   asynchronous active-low reset of Sum_q/Cout_q
//   A, B    [WIDTH-1:0] unsigned operands
//   Cin     carry-in
//   Sum     [WIDTH-1:0] (A+B+Cin) mod 2^WIDTH, combinational
//   Cout    bit WIDTH of A+B+Cin, combinational
//   Sum_q   Sum registered on the rising edge of clk
//   Cout_q  Cout registered on the rising edge of clk
// -----------------------------------------------------------------------------
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q
);

    localparam int NG = num_groups(WIDTH);                 // 4-bit groups
    localparam int NC = (NG + GROUP_W - 1) / GROUP_W;       // clusters of four groups

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "cla_adder: WIDTH=%0d must be a multiple of %0d in the range %0d..%0d",
               WIDTH, GROUP_W, GROUP_W, MAX_WIDTH);
    end

    logic [NG-1:0]           grp_gg;
    logic [NG-1:0]           grp_gp;
    gpg_t [GROUP_W*NC-1:0]   grp_pad;   // group pairs, top cluster padded out
    gpg_t [GROUP_W-1:0]      clu_pg;    // cluster pairs, padded to four clusters
    logic [NC-1:0]           clu_cin;   // carry into each cluster
    logic [NG:0]             gc;        // carry into each group; gc[NG] is Cout

    // ---------------------------------------------------------------------
    // Level 1: 4-bit lookahead slices
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group4 u_grp (
            .a   (A[GROUP_W*gi +: GROUP_W]),
            .b   (B[GROUP_W*gi +: GROUP_W]),
            .cin (gc[gi]),
            .sum (Sum[GROUP_W*gi +: GROUP_W]),
            .gg  (grp_gg[gi]),
            .gp  (grp_gp[gi])
        );
    end

    // Missing groups in a partly used top cluster act as "kill" (gg=0, gp=0),
    // which leaves the carries of the real groups untouched.
    for (genvar gi = 0; gi < GROUP_W*NC; gi++) begin : g_pad
        if (gi < NG) begin : g_real
            assign grp_pad[gi] = '{gg: grp_gg[gi], gp: grp_gp[gi]};
        end else begin : g_kill
            assign grp_pad[gi] = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Level 3: cluster {GG, GP} and the carry into each cluster from Cin.
    // With a single cluster (WIDTH <= 16) this collapses to clu_cin[0] = Cin.
    // ---------------------------------------------------------------------
    for (genvar ck = 0; ck < GROUP_W; ck++) begin : g_clu
        if (ck < NC) begin : g_real
            assign clu_pg[ck]  = group_pg(grp_pad[GROUP_W*ck +: GROUP_W]);
            assign clu_cin[ck] = carry_at(clu_pg, Cin, 3'(ck));
        end else begin : g_kill
            assign clu_pg[ck] = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Level 2: carry into each group, looked ahead from its cluster's carry-in.
    // Position 4 of a cluster's lookahead is that cluster's carry-out, which
    // gives the carry into the first group of the next cluster (or Cout).
    // ---------------------------------------------------------------------
    assign gc[0] = Cin;

    for (genvar gi = 1; gi <= NG; gi++) begin : g_gc
        localparam int CK = (gi - 1) / GROUP_W;
        localparam int CJ = (gi - 1) % GROUP_W + 1;
        assign gc[gi] = carry_at(grp_pad[GROUP_W*CK +: GROUP_W], clu_cin[CK], 3'(CJ));
    end

    assign Cout = gc[NG];

    // ---------------------------------------------------------------------
    // Registered copy of the result
    // ---------------------------------------------------------------------
    logic [WIDTH:0] result_d;
    logic [WIDTH:0] result_q;

    always_comb begin
        result_d = {Cout, Sum};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign Sum_q  = result_q[WIDTH-1:0];
    assign Cout_q = result_q[WIDTH];

endmodule

// File: tb/tb_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_adder
//
// Four adders (8, 16, 32, 64 bits) share one 64-bit stimulus, truncated per
// width. The driver pushes the expected {Cout, Sum} of every width into a
// queue; a monitor pops it at the falling edge and compares the combinational
// outputs, and compares the registered outputs against a reference register
// fed from the previously popped expectation.
// -----------------------------------------------------------------------------
module tb_cla_adder;

    localparam int NW       = 4;
    localparam int WIDTHS [NW] = '{8, 16, 32, 64};
    localparam int N_RANDOM = 10000;
    localparam int N_DIR    = 8;

    typedef logic [NW-1:0][64:0] exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        cin_in;

    logic [7:0]  s8,  sq8;
    logic [15:0] s16, sq16;
    logic [31:0] s32, sq32;
    logic [63:0] s64, sq64;
    logic        c8, cq8, c16, cq16, c32, cq32, c64, cq64;

    cla_adder #(.WIDTH(8)) u_add8 (
        .clk(clk), .rst_n(rst_n), .A(a_in[7:0]), .B(b_in[7:0]), .Cin(cin_in),
        .Sum(s8), .Cout(c8), .Sum_q(sq8), .Cout_q(cq8));
    cla_adder #(.WIDTH(16)) u_add16 (
        .clk(clk), .rst_n(rst_n), .A(a_in[15:0]), .B(b_in[15:0]), .Cin(cin_in),
        .Sum(s16), .Cout(c16), .Sum_q(sq16), .Cout_q(cq16));
    cla_adder #(.WIDTH(32)) u_add32 (
        .clk(clk), .rst_n(rst_n), .A(a_in[31:0]), .B(b_in[31:0]), .Cin(cin_in),
        .Sum(s32), .Cout(c32), .Sum_q(sq32), .Cout_q(cq32));
    cla_adder #(.WIDTH(64)) u_add64 (
        .clk(clk), .rst_n(rst_n), .A(a_in), .B(b_in), .Cin(cin_in),
        .Sum(s64), .Cout(c64), .Sum_q(sq64), .Cout_q(cq64));

    logic [64:0] act_c [NW];
    logic [64:0] act_r [NW];

    assign act_c[0] = 65'({c8,  s8});
    assign act_c[1] = 65'({c16, s16});
    assign act_c[2] = 65'({c32, s32});
    assign act_c[3] = {c64, s64};
    assign act_r[0] = 65'({cq8,  sq8});
    assign act_r[1] = 65'({cq16, sq16});
    assign act_r[2] = 65'({cq32, sq32});
    assign act_r[3] = {cq64, sq64};

    always #10 clk = ~clk;

    exp_t exp_q [$];
    exp_t cur_exp = '0;   // expectation for the inputs currently applied
    exp_t reg_exp = '0;   // expectation for the registered outputs
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cout_hits [NW] = '{0, 0, 0, 0};

    // Reference: plain unsigned arithmetic on the truncated operands.
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input int w);
        logic [65:0] mask;
        logic [65:0] s;
        mask = (66'd1 << w) - 66'd1;
        s    = ({2'b00, a} & mask) + ({2'b00, b} & mask) + 66'(cin);
        return s[64:0];
    endfunction

    function automatic exp_t make_exp(input logic [63:0] a, input logic [63:0] b,
                                      input logic cin);
        exp_t e;
        for (int w = 0; w < NW; w++) e[w] = ref_sum(a, b, cin, WIDTHS[w]);
        return e;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (A=%h B=%h Cin=%b t=%0t)",
                     name, act, exp_v, a_in, b_in, cin_in, $time);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin);
        @(posedge clk);
        #1;
        a_in   = a;
        b_in   = b;
        cin_in = cin;
        exp_q.push_back(make_exp(a, b, cin));
    endtask

    // Reference register: cleared by reset at once, otherwise loads the
    // expectation of the inputs present at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_exp <= '0;
        else        reg_exp <= cur_exp;
    end

    // Monitor: registered outputs every falling edge, combinational outputs
    // whenever a new expectation is waiting.
    initial begin
        forever begin
            @(negedge clk);
            for (int w = 0; w < NW; w++)
                check($sformatf("reg_w%0d", WIDTHS[w]), act_r[w], reg_exp[w]);
            if (exp_q.size() > 0) begin
                cur_exp = exp_q.pop_front();
                for (int w = 0; w < NW; w++) begin
                    check($sformatf("comb_w%0d", WIDTHS[w]), act_c[w], cur_exp[w]);
                    if (cur_exp[w][WIDTHS[w]]) cout_hits[w]++;
                end
            end
        end
    end

    // Asynchronous reset must clear the registered outputs without a clock.
    initial begin
        forever begin
            @(negedge rst_n);
            #1;
            for (int w = 0; w < NW; w++)
                check($sformatf("rst_now_w%0d", WIDTHS[w]), act_r[w], 65'd0);
        end
    end

    localparam logic [63:0] DIR_A [N_DIR] = '{
        64'h65, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF,
        64'hAA, 64'h7F, 64'hA5A5, 64'hFE};
    localparam logic [63:0] DIR_B [N_DIR] = '{
        64'h65, 64'h0, 64'h0, 64'h01,
        64'h55, 64'h01, 64'h5A5A, 64'h01};
    localparam logic DIR_C [N_DIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        rst_n  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        #15 rst_n = 1'b1;

        for (int i = 0; i < N_DIR; i++) issue(DIR_A[i], DIR_B[i], DIR_C[i]);

        // Reset between edges with a nonzero sum present, then release.
        issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        #4 rst_n = 1'b0;
        @(posedge clk);
        #5 rst_n = 1'b1;
        issue(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0);

        for (int i = 0; i < N_RANDOM; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                2:       b = ~a;                                          // full propagate
                3:       b = ~a ^ (64'd1 << $urandom_range(0, 63));       // long chain, one break
                default: ;
            endcase
            issue(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 65'(exp_q.size()), 65'd0);
        for (int w = 0; w < NW; w++)
            if (cout_hits[w] == 0) begin
                n_fail++;
                $display("FAIL cout_cover_w%0d: got 0 carry-out hits, required at least 1",
                         WIDTHS[w]);
            end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
